node_task_agent: RTL

Per-node task agent; next generation of the node self-awareness poller. Polls the control unit over AXI-light for a task address and drives the CPU's activate/axi_offset. Measures busy cycles, enforces an optional watchdog timeout, and reports a status word (cycle count, timeout flag) back to the control unit. Handles AXI error responses with bounded write retry. Sits between each CPU node wrapper and the AXI-light interconnect.

---
 rtl/node_task_agent_pkg.sv | 42 ++++
 rtl/if_axi_light.sv | 25 ++
 rtl/sat_counter.sv | 38 +++
 rtl/node_task_agent.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/node_task_agent_pkg.sv
// Shared state encoding, bus constants and status-word packing for node_task_agent.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package node_task_agent_pkg;

    typedef enum logic [2:0] {
        GAP        = 3'd0,
        READ       = 3'd1,
        READ_WAIT  = 3'd2,
        EVAL       = 3'd3,
        RUN        = 3'd4,
        WRITE      = 3'd5,
        WRITE_WAIT = 3'd6
    } state_e;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int          AXI_AW         = `AXI_ADDR_WIDTH;
    localparam int          AXI_DW         = `AXI_DATA_WIDTH;
    localparam int          STATUS_TO_BIT  = AXI_DW - 1;
    localparam logic [63:0] STATUS_CNT_MAX = (64'd1 << STATUS_TO_BIT) - 64'd1;

    // A zero word would look like "no report", so a zero count still sets bit 0.
    function automatic logic [AXI_DW-1:0] pack_status(input logic timed_out, input logic [63:0] cnt);
        logic [AXI_DW-1:0] word;
        word                = '0;
        word[STATUS_TO_BIT] = timed_out;
        if (cnt == 64'd0) begin
            word[0] = 1'b1;
        end else if (cnt > STATUS_CNT_MAX) begin
            word[STATUS_TO_BIT-1:0] = '1;
        end else begin
            word[STATUS_TO_BIT-1:0] = cnt[STATUS_TO_BIT-1:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/if_axi_light.sv
// Single-outstanding AXI-light bus between a node agent (master) and the interconnect.
interface if_axi_light;
    logic [`AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                         awvalid;
    logic                         awready;
    logic [`AXI_DATA_WIDTH-1:0]   wdata;
    logic [`AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                         wvalid;
    logic                         wready;
    logic [1:0]                   bresp;
    logic                         bvalid;
    logic                         bready;
    logic [`AXI_ADDR_WIDTH-1:0]   araddr;
    logic                         arvalid;
    logic                         arready;
    logic [`AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sat_counter.sv
// Clearable accumulator that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH:0]   sum_s;

    // Next count: clear has priority, carry-out clamps to all-ones.
    always_comb begin
        sum_s = {1'b0, cnt_q} + {1'b0, inc};
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = sum_s[WIDTH] ? '1 : sum_s[WIDTH-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;
endmodule

// File: rtl/node_task_agent.sv
// Per-node task agent: polls for a task address, runs the CPU, reports a status word.
// Optional NODE_TASK_AGENT_STATS_EN adds task_count / total_busy statistics outputs.
module node_task_agent
    import node_task_agent_pkg::*;
#(
    parameter int ID         = 0,
    parameter int NODE_MSB   = 6,
    parameter int NODE_LSB   = 2,
    parameter int PROG_INDEX = 7,
    parameter int POLL_GAP   = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = 0,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 fin,
    output logic                 activate,
    output logic [AXI_AW-1:0]    axi_offset,
    output logic [CNT_WIDTH-1:0] busy_cycles,
    output logic                 timed_out,
    output logic                 rd_err,
`ifdef NODE_TASK_AGENT_STATS_EN
    output logic [31:0]          task_count,
    output logic [63:0]          total_busy,
`endif
    if_axi_light.master          m_axi
);
    localparam int NODE_W  = NODE_MSB - NODE_LSB + 1;
    localparam int GAP_W   = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [GAP_W-1:0]     GAP_RELOAD = GAP_W'(POLL_GAP);
    localparam logic [RETRY_W-1:0]   RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam bit                   TO_EN      = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] TO_VALUE   = CNT_WIDTH'(TIMEOUT);
    localparam logic [AXI_AW-1:0]    ADDR_ID    = (AXI_AW'(1) << (AXI_AW - 1))
                                                | (AXI_AW'(1) << PROG_INDEX)
                                                | (AXI_AW'(ID % (1 << NODE_W)) << NODE_LSB);

    state_e                 state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   activate_q, activate_d;
    logic [AXI_AW-1:0]      axi_offset_q, axi_offset_d;
    logic [CNT_WIDTH-1:0]   busy_cycles_q, busy_cycles_d;
    logic                   timed_out_q, timed_out_d;
    logic                   rd_err_q, rd_err_d;
    logic [AXI_DW-1:0]      rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic [AXI_DW-1:0]      wdata_q, wdata_d;
    logic                   busy_clr_s, busy_en_s, busy_sat_s, run_exit_s;
    logic [CNT_WIDTH-1:0]   busy_cnt_s;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_busy_cnt (
        .clk(clk), .rst_n(res_n), .clr(busy_clr_s), .en(busy_en_s),
        .inc(CNT_WIDTH'(1)), .cnt(busy_cnt_s), .sat(busy_sat_s)
    );

    // Next-state, bus handshakes and task bookkeeping.
    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        retry_d       = retry_q;
        activate_d    = activate_q;
        axi_offset_d  = axi_offset_q;
        busy_cycles_d = busy_cycles_q;
        timed_out_d   = timed_out_q;
        rd_err_d      = rd_err_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        wdata_d       = wdata_q;
        busy_clr_s    = 1'b0;
        run_exit_s    = 1'b0;
        busy_en_s     = (state_q == RUN) && !fin && !busy_sat_s;
        case (state_q)
            GAP: begin
                if (gap_q == '0 || gap_q == GAP_W'(1)) begin
                    gap_d     = '0;
                    arvalid_d = 1'b1;
                    state_d   = READ;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            READ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = READ_WAIT;
                end else begin
                    state_d = READ;
                end
            end
            READ_WAIT: begin
                if (m_axi.rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axi.rdata;
                    rresp_d  = m_axi.rresp;
                    state_d  = EVAL;
                end else begin
                    state_d = READ_WAIT;
                end
            end
            EVAL: begin
                if (rresp_q != AXI_RESP_OKAY) begin
                    rd_err_d = 1'b1;
                    gap_d    = GAP_RELOAD;
                    state_d  = GAP;
                end else if (rdata_q == '0) begin
                    gap_d   = GAP_RELOAD;
                    state_d = GAP;
                end else begin
                    activate_d   = 1'b1;
                    axi_offset_d = AXI_AW'(rdata_q);
                    timed_out_d  = 1'b0;
                    busy_clr_s   = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // fin is checked first so a same-cycle finish is never reported as a timeout.
                if (fin || (TO_EN && busy_cnt_s == TO_LAST)) begin
                    busy_cycles_d = fin ? busy_cnt_s : TO_VALUE;
                    timed_out_d   = !fin;
                    activate_d    = 1'b0;
                    axi_offset_d  = '0;
                    run_exit_s    = 1'b1;
                    retry_d       = '0;
                    awvalid_d     = 1'b1;
                    wvalid_d      = 1'b1;
                    wdata_d       = pack_status(timed_out_d, 64'(busy_cycles_d));
                    state_d       = WRITE;
                end else begin
                    state_d = RUN;
                end
            end
            WRITE: begin
                awvalid_d = awvalid_q && !m_axi.awready;
                wvalid_d  = wvalid_q && !m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRITE_WAIT;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE_WAIT: begin
                if (!m_axi.bvalid) begin
                    state_d = WRITE_WAIT;
                end else if (m_axi.bresp != AXI_RESP_OKAY && retry_q < RETRY_MAX) begin
                    bready_d  = 1'b0;
                    retry_d   = retry_q + RETRY_W'(1);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WRITE;
                end else begin
                    bready_d = 1'b0;
                    gap_d    = GAP_RELOAD;
                    state_d  = GAP;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                gap_d     = GAP_RELOAD;
                state_d   = GAP;
            end
        endcase
    end

    // State and output registers; reset abandons any bus transaction in flight.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q       <= GAP;
            gap_q         <= GAP_RELOAD;
            retry_q       <= '0;
            activate_q    <= 1'b0;
            axi_offset_q  <= '0;
            busy_cycles_q <= '0;
            timed_out_q   <= 1'b0;
            rd_err_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= AXI_RESP_OKAY;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            retry_q       <= retry_d;
            activate_q    <= activate_d;
            axi_offset_q  <= axi_offset_d;
            busy_cycles_q <= busy_cycles_d;
            timed_out_q   <= timed_out_d;
            rd_err_q      <= rd_err_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            wdata_q       <= wdata_d;
        end
    end

`ifdef NODE_TASK_AGENT_STATS_EN
    logic task_sat_s, total_sat_s;

    sat_counter #(.WIDTH(32)) u_task_cnt (
        .clk(clk), .rst_n(res_n), .clr(1'b0), .en(run_exit_s && !task_sat_s),
        .inc(32'd1), .cnt(task_count), .sat(task_sat_s)
    );

    sat_counter #(.WIDTH(64)) u_total_busy (
        .clk(clk), .rst_n(res_n), .clr(1'b0), .en(run_exit_s && !total_sat_s),
        .inc(64'(busy_cycles_d)), .cnt(total_busy), .sat(total_sat_s)
    );
`endif

    assign activate      = activate_q;
    assign axi_offset    = axi_offset_q;
    assign busy_cycles   = busy_cycles_q;
    assign timed_out     = timed_out_q;
    assign rd_err        = rd_err_q;
    assign m_axi.araddr  = ADDR_ID;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awaddr  = ADDR_ID;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
endmodule
